// File: rtl/x2p_apb_master.sv
// rtl/x2p_apb_master.sv - request/response to APB master bridge with address decode and wait timeout
module x2p_apb_master #(
  parameter int DATA_LENGTH = 32,
  parameter int NUM_SLAVE   = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                            pclk,
  input  logic                            preset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [DATA_LENGTH-1:0]          req_addr,
  input  logic                            req_write,
  input  logic [DATA_LENGTH-1:0]          req_wdata,
  input  logic [3:0]                      req_strb,
  input  logic [2:0]                      req_prot,
  output logic                            rsp_valid,
  output logic [DATA_LENGTH-1:0]          rsp_rdata,
  output logic                            rsp_slverr,
  output logic                            rsp_timeout,
  output logic [NUM_SLAVE-1:0]            psel,
  output logic [DATA_LENGTH-1:0]          paddr,
  output logic [2:0]                      pprot,
  output logic                            penable,
  output logic                            pwrite,
  output logic [DATA_LENGTH-1:0]          pwdata,
  output logic [3:0]                      pstrb,
  input  logic [NUM_SLAVE-1:0]            pready,
  input  logic [NUM_SLAVE*DATA_LENGTH-1:0] prdata,
  input  logic [NUM_SLAVE-1:0]            pslverr
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] NS_W = 3'(NUM_SLAVE);
  localparam logic [CW-1:0] TO_W = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             idx;
  logic [CW-1:0]          wait_cnt;
  logic                   handshake;
  logic                   sel_ready;
  logic                   sel_err;
  logic [DATA_LENGTH-1:0] sel_rdata;
  logic                   timeout_hit;
  logic [1:0]             req_idx;

  assign req_ready = preset_n && (state == IDLE);
  assign handshake = req_valid && req_ready;
  assign req_idx   = req_addr[SEL_LSB+1:SEL_LSB];
  assign penable   = (state == ACCESS);

  // Only the addressed slave's return signals are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    psel      = '0;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      if (idx == i[1:0]) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_LENGTH +: DATA_LENGTH];
        psel[i]   = (state == SETUP) || (state == ACCESS);
      end
    end
  end

  // The limit is checked one cycle after the last counted wait, so a late pready still wins.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == TO_W) && !sel_ready;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = ({1'b0, req_idx} < NS_W) ? SETUP : DECERR;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_nxt = IDLE;
      DECERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      idx         <= '0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      if (handshake) begin
        idx    <= req_idx;
        paddr  <= req_addr;
        pwdata <= req_wdata;
        pstrb  <= req_strb;
        pprot  <= req_prot;
        pwrite <= req_write;
      end
      if (state == SETUP) wait_cnt <= '0;
      if (state == ACCESS) begin
        if (sel_ready) begin
          rsp_valid  <= 1'b1;
          rsp_rdata  <= pwrite ? '0 : sel_rdata;
          rsp_slverr <= sel_err;
        end else if (timeout_hit) begin
          rsp_valid   <= 1'b1;
          rsp_slverr  <= 1'b1;
          rsp_timeout <= 1'b1;
        end else if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
      if (state == DECERR) begin
        rsp_valid  <= 1'b1;
        rsp_slverr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_x2p_apb_master.sv
// tb/tb_x2p_apb_master.sv - randomized and directed bench for x2p_apb_master against a transaction-level model
module tb_x2p_apb_master;

  localparam int DL = 32;
  localparam int NS = 3;
  localparam int SL = 12;
  localparam int TO = 16;

  logic               pclk = 1'b0;
  logic               preset_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [DL-1:0]      req_addr = '0;
  logic               req_write = 1'b0;
  logic [DL-1:0]      req_wdata = '0;
  logic [3:0]         req_strb = '0;
  logic [2:0]         req_prot = '0;
  logic               rsp_valid;
  logic [DL-1:0]      rsp_rdata;
  logic               rsp_slverr;
  logic               rsp_timeout;
  logic [NS-1:0]      psel;
  logic [DL-1:0]      paddr;
  logic [2:0]         pprot;
  logic               penable;
  logic               pwrite;
  logic [DL-1:0]      pwdata;
  logic [3:0]         pstrb;
  logic [NS-1:0]      pready = '0;
  logic [NS*DL-1:0]   prdata = '0;
  logic [NS-1:0]      pslverr = '0;

  int n_checks = 0;
  int n_pass = 0;

  x2p_apb_master #(.DATA_LENGTH(DL), .NUM_SLAVE(NS), .SEL_LSB(SL), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .paddr(paddr), .pprot(pprot), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Non-selected slaves always present ready/error/random data to prove they are ignored.
  task automatic set_slaves(input int sel, input bit rdy, input logic [DL-1:0] rd, input bit er);
    for (int i = 0; i < NS; i++) begin
      if (i == sel) begin
        pready[i] = rdy;
        prdata[i*DL +: DL] = rd;
        pslverr[i] = er;
      end else begin
        pready[i] = 1'b1;
        prdata[i*DL +: DL] = $urandom;
        pslverr[i] = 1'b1;
      end
    end
  endtask

  // Called at a negedge while the DUT is idle or in a response cycle; returns at the response-cycle negedge.
  task automatic xfer(input logic [DL-1:0] addr, input bit wr, input logic [DL-1:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int waits,
                      input bit err, input logic [DL-1:0] rd);
    int idx;
    bit dec;
    bit tmo;
    int acc;
    logic [NS-1:0] exp_sel;
    idx = int'((addr >> SL) & 32'h3);
    dec = (idx >= NS);
    tmo = !dec && (waits > TO);
    acc = tmo ? TO + 1 : waits + 1;
    exp_sel = '0;
    if (!dec) exp_sel[idx] = 1'b1;

    check("req_ready_offer", req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_strb = st; req_prot = pr;
    @(negedge pclk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~wr; req_strb = ~st; req_prot = ~pr;
    check("req_ready_busy", req_ready, 0);
    check("rsp_valid_early", rsp_valid, 0);
    if (dec) begin
      check("dec_psel", psel, 0);
      check("dec_penable", penable, 0);
      set_slaves(-1, 1'b0, '0, 1'b0);
    end else begin
      check("setup_psel", psel, exp_sel);
      check("setup_penable", penable, 0);
      check("setup_paddr", paddr, addr);
      check("setup_pwrite", pwrite, wr);
      check("setup_pwdata", pwdata, wd);
      check("setup_pstrb", pstrb, st);
      check("setup_pprot", pprot, pr);
      set_slaves(idx, 1'b1, ~rd, ~err);
      for (int a = 1; a <= acc; a++) begin
        @(negedge pclk);
        check("access_psel", psel, exp_sel);
        check("access_penable", penable, 1);
        check("access_paddr", paddr, addr);
        check("access_pwrite", pwrite, wr);
        check("access_pwdata", pwdata, wd);
        check("access_pstrb", pstrb, st);
        check("access_pprot", pprot, pr);
        check("access_rsp_valid", rsp_valid, 0);
        check("access_req_ready", req_ready, 0);
        set_slaves(idx, (a == waits + 1), rd, err);
      end
    end
    @(negedge pclk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_slverr", rsp_slverr, (dec || tmo) ? 1'b1 : err);
    check("rsp_timeout", rsp_timeout, tmo);
    check("rsp_rdata", rsp_rdata, (dec || tmo || wr) ? '0 : rd);
    check("rsp_psel", psel, 0);
    check("rsp_penable", penable, 0);
    check("rsp_req_ready", req_ready, 1);
    set_slaves(-1, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge pclk);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_psel", psel, 0);
      check("idle_req_ready", req_ready, 1);
    end
  endtask

  initial begin
    set_slaves(-1, 1'b0, '0, 1'b0);
    repeat (2) @(negedge pclk);
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_pprot", pprot, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    preset_n = 1'b1;
    @(negedge pclk);
    check("post_rst_req_ready", req_ready, 1);

    xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0);
    idle(1);
    xfer(32'h0000_2000, 1'b0, 32'h0, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678);
    idle(1);
    xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3'b001, 1000, 1'b0, 32'hAAAA_5555);
    idle(1);
    xfer(32'h0000_3000, 1'b1, 32'h5A5A_5A5A, 4'h3, 3'b100, 0, 1'b0, 32'h0);
    idle(1);
    xfer(32'h0000_1100, 1'b0, 32'h0, 4'hF, 3'b000, 1, 1'b1, 32'hCAFE_F00D);
    xfer(32'h0000_2204, 1'b1, 32'h0BAD_CAFE, 4'h5, 3'b011, 0, 1'b0, 32'h0);
    xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 3'b000, TO, 1'b0, 32'h7777_8888);
    xfer(32'h0000_1008, 1'b0, 32'h0, 4'hF, 3'b000, TO - 1, 1'b1, 32'h1111_2222);
    xfer(32'h0000_200C, 1'b0, 32'h0, 4'hF, 3'b000, TO + 1, 1'b0, 32'h3333_4444);
    idle(2);

    // Reset dropped mid-ACCESS: bus released at once, no response afterwards.
    req_valid = 1'b1; req_addr = 32'h0000_1000; req_write = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    set_slaves(1, 1'b0, 32'h9999_9999, 1'b0);
    repeat (2) @(negedge pclk);
    check("pre_rst_penable", penable, 1);
    #2 preset_n = 1'b0;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    check("async_rst_req_ready", req_ready, 0);
    @(negedge pclk);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    preset_n = 1'b1;
    set_slaves(-1, 1'b0, '0, 1'b0);
    @(negedge pclk);
    check("rst_mid_rsp_valid_after", rsp_valid, 0);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_psel", psel, 0);

    for (int t = 0; t < 40; t++) begin
      logic [DL-1:0] a;
      int w;
      int sel;
      a = $urandom;
      w = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      if (sel < 6)       w = $urandom_range(0, 4);
      else if (sel == 6) w = TO;
      else if (sel == 7) w = TO + 1;
      else if (sel == 8) w = TO - 1;
      else               w = $urandom_range(5, 25);
      xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), w, 1'($urandom), $urandom);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/x2p_apb_master.md
X2P_APB_MASTER -- requirements
Module: x2p_apb_master

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_LENGTH, default 32, which sets the width of address and data.
REQ-002 The block SHALL have parameter NUM_SLAVE, default 4 (range 1..4), which sets the number of APB slaves.
REQ-003 The block SHALL have parameter SEL_LSB, default 12; the slave index is paddr[SEL_LSB+1:SEL_LSB].
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 16; it sets the maximum number of ACCESS wait cycles, and 0 disables the timeout.

Ports:
REQ-005 The block SHALL have the following ports:
- pclk, in, 1: the single clock.
- preset_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request offered.
- req_ready, out, 1: request accepted when high together with req_valid.
- req_addr, in, DATA_LENGTH: address.
- req_write, in, 1: 1 = write.
- req_wdata, in, DATA_LENGTH: write data.
- req_strb, in, 4: write byte strobes.
- req_prot, in, 3: protection.
- rsp_valid, out, 1: one-cycle response pulse.
- rsp_rdata, out, DATA_LENGTH: read data.
- rsp_slverr, out, 1: error response.
- rsp_timeout, out, 1: the error was caused by timeout.
- psel, out, NUM_SLAVE: one-hot slave select.
- paddr / pprot / penable / pwrite / pwdata / pstrb, out, DATA_LENGTH / 3 / 1 / 1 / DATA_LENGTH / 4: APB master bundle.
- pready, in, NUM_SLAVE: per-slave ready.
- prdata, in, NUM_SLAVE*DATA_LENGTH: per-slave read data, slave i at bits [i*DATA_LENGTH +: DATA_LENGTH].
- pslverr, in, NUM_SLAVE: per-slave error.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, ACCESS and DECERR.
REQ-007 req_ready SHALL be 1 only in IDLE.
REQ-008 A request SHALL be captured into internal registers on the handshake (req_valid & req_ready).
REQ-009 In IDLE, on handshake:
- If the index is below NUM_SLAVE, the FSM SHALL go to SETUP.
- Otherwise the FSM SHALL go to DECERR.
REQ-010 In SETUP:
- psel[idx] = 1 and penable = 0.
- paddr/pprot/pwrite/pwdata/pstrb SHALL come from the captured registers.
- The FSM SHALL go to ACCESS on the next cycle unconditionally.
REQ-011 In ACCESS:
- psel[idx] = 1 and penable = 1.
- The APB bundle SHALL hold stable until completion.
REQ-012 In ACCESS, when pready[idx] = 1:
- Completion: rsp_valid = 1 on the next cycle.
- rsp_rdata SHALL equal prdata[idx] for a read and 0 for a write.
- rsp_slverr SHALL equal pslverr[idx]; rsp_timeout = 0.
- The FSM SHALL return to IDLE.
REQ-013 Latency with zero wait states: handshake at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid and req_ready both high in cycle N+3.
REQ-014 A new request SHALL be accepted in the same cycle that rsp_valid is high (back-to-back).
REQ-015 The wait counter SHALL:
- clear on entering ACCESS;
- increment each ACCESS cycle with pready[idx] = 0;
- saturate and never wrap.
REQ-016 When TIMEOUT_CYC ≠ 0 and the wait counter reaches TIMEOUT_CYC with pready[idx] still 0:
- The transfer SHALL abort, with psel = 0 and penable = 0 on the next cycle.
- rsp_valid SHALL pulse with rsp_slverr = 1, rsp_timeout = 1 and rsp_rdata = 0.
- The FSM SHALL return to IDLE.
REQ-017 If pready[idx] = 1 in the same cycle the counter reaches its limit, the transfer SHALL complete normally with no timeout.
REQ-018 DECERR SHALL last one cycle:
- No psel is asserted.
- rsp_valid SHALL pulse with rsp_slverr = 1, rsp_timeout = 0 and rsp_rdata = 0.
- The FSM SHALL return to IDLE.
REQ-019 pready, prdata and pslverr of non-selected slaves SHALL be ignored.
REQ-020 At most one psel bit SHALL ever be high.
REQ-021 rsp_valid SHALL be high for exactly one cycle per accepted request, and the response outputs SHALL be registered.
REQ-022 paddr, pwdata and pwrite MAY retain their last values in IDLE.

Reset
REQ-023 When preset_n = 0, asynchronously, the block SHALL force:
- state = IDLE;
- psel = 0, penable = 0;
- paddr / pwdata / pstrb / pprot / pwrite = 0;
- rsp_valid / rsp_slverr / rsp_timeout = 0, rsp_rdata = 0;
- wait counter = 0.
REQ-024 req_ready SHALL be 0 while preset_n = 0 and SHALL be 1 in the first cycle after deassertion.
REQ-025 Reset asserted mid-transfer SHALL drop psel and penable immediately, with no response issued.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Zero-wait write: addr 0x0000_1004, wdata 0xDEAD_BEEF, strb 0xF, slave 1 pready = 1. Required: psel = 4'b0010; SETUP then ACCESS; rsp_valid at N+3 with slverr = 0.
- Read, 3 wait states: addr 0x0000_2000, slave 2 returns 0x1234_5678 on the 4th ACCESS cycle. Required: penable high for 4 cycles; rsp_rdata = 0x1234_5678 at N+6.
- Timeout: TIMEOUT_CYC = 16, slave 0 pready stuck 0. Required: abort after 16 wait cycles; rsp_slverr = 1, rsp_timeout = 1; psel cleared.
- Decode error: NUM_SLAVE = 3, addr 0x0000_3000. Required: no psel asserted; rsp_valid one cycle after handshake with slverr = 1.
- Back-to-back: second request held valid during the first response. Required: accepted in the rsp_valid cycle; next SETUP follows immediately.
- Reset mid-ACCESS: preset_n pulled low. Required: psel and penable go to 0 asynchronously; no rsp_valid; req_ready = 1 after release.
